// File: rtl/regfile_wr_demux.sv
// Register-file write demux: buffers writes in order and issues a registered one-hot reg_we two edges after acceptance, with bypass lookup.
// wr_ready drops when the buffer is full; hold freezes issue. Define REGFILE_ZERO_REG_EN to make register NUM_REGS-1 hardwired zero.
module regfile_wr_demux #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                hold,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                byp_hit,
  output logic [DATA_W-1:0]   byp_data,
  output logic                busy
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   NREG     = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0]   r_buf_addr [DEPTH];
  logic [DATA_W-1:0]   r_buf_data [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_push;
  logic                w_pop;
  logic [NUM_REGS-1:0] w_we_next;
  logic                w_hit;
  logic [DATA_W-1:0]   w_bdata;

  // Addresses past the array, and the zero register when enabled, are never written.
  function automatic logic f_writable(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < NREG);
    if (ZERO_EN && (a == ZERO_REG)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (r_count < FULL_CNT);
  assign w_push   = wr_valid & wr_ready;
  assign w_pop    = (r_count != '0) & ~hold;
  assign busy     = (r_count != '0) | (|reg_we);

  always_comb begin
    w_we_next = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      if (f_writable(r_buf_addr[r_head]) && (r_buf_addr[r_head] == ADDR_W'(j)))
        w_we_next[j] = 1'b1;
    end
  end

  // Output stage has lowest priority; buffer entries are scanned oldest first so the youngest match wins.
  always_comb begin
    logic [PTR_W:0] w_sum;
    w_hit   = 1'b0;
    w_bdata = '0;
    w_sum   = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      if (reg_we[j] && (rd_addr == ADDR_W'(j))) begin
        w_hit   = 1'b1;
        w_bdata = reg_wdata;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_sum = {1'b0, r_head} + (PTR_W + 1)'(i);
      if (w_sum >= (PTR_W + 1)'(DEPTH)) w_sum = w_sum - (PTR_W + 1)'(DEPTH);
      if ((CNT_W'(i) < r_count) && f_writable(rd_addr) &&
          (r_buf_addr[w_sum[PTR_W-1:0]] == rd_addr)) begin
        w_hit   = 1'b1;
        w_bdata = r_buf_data[w_sum[PTR_W-1:0]];
      end
    end
  end

  assign byp_hit  = w_hit;
  assign byp_data = w_bdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      reg_we    <= '0;
      reg_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_buf_addr[r_tail] <= wr_addr;
        r_buf_data[r_tail] <= wr_data;
        r_tail             <= f_inc(r_tail);
      end
      if (w_pop) begin
        reg_we    <= w_we_next;
        reg_wdata <= r_buf_data[r_head];
        r_head    <= f_inc(r_head);
      end else begin
        reg_we    <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
